// File: rtl/hdmi_pkg.sv
// Shared constants for HDMI 1.4 data-island packet assembly.
// Latency: n/a (constants only).
// Backpressure: n/a.
package hdmi_pkg;

  // BCH generator G(x)=1+x^6+x^7+x^8, in the reflected form used by the LSB-first serial update
  localparam logic [7:0] BCH_POLY = 8'h83;

  // Packet geometry in bits and pixels
  localparam int PKT_LEN  = 32;
  localparam int HDR_BITS = 24;
  localparam int SUB_BITS = 56;

  localparam logic [4:0] LAST_PIXEL = 5'(PKT_LEN - 1);
  localparam logic [4:0] HDR_PIXELS = 5'(HDR_BITS);
  localparam logic [4:0] SUB_PIXELS = 5'(SUB_BITS / 2);

endpackage

// File: rtl/bch_ecc_step.sv
// One serial BCH ECC update for a single LSB-first data bit.
// Latency: combinational.
// Backpressure: none.
module bch_ecc_step
  import hdmi_pkg::*;
(
  input  logic [7:0] ecc_in,
  input  logic       data,
  output logic [7:0] ecc_out
);

  assign ecc_out = (ecc_in >> 1) ^ ((ecc_in[0] ^ data) ? BCH_POLY : 8'h00);

endmodule

// File: rtl/packet_assembler.sv
// Serialises a header and four subpackets into 32 pixels of data-island bits with BCH ECC.
// Latency: packet_data/packet_end are combinational from the pixel counter and ECC state.
// Backpressure: none; upstream must hold header/sub stable for the full 32-pixel packet.
module packet_assembler
  import hdmi_pkg::*;
(
  input  logic              clk_pixel,
  input  logic              rst_n,
  input  logic              data_island_period,
  input  logic [23:0]       header,
  input  logic [3:0][55:0]  sub,
  output logic [4:0]        counter,
  output logic [8:0]        packet_data,
  output logic              packet_end
);

  logic       active;
  logic       ecc_clear;
  logic       hdr_phase;
  logic       sub_phase;
  logic [7:0] hdr_ecc;
  logic [7:0] hdr_ecc_next;
  logic       hdr_bit;
  logic [3:0] even_bits;
  logic [3:0] odd_bits;

  // Outputs are forced quiet while reset is held, even if an island is signalled
  assign active    = data_island_period & rst_n;
  assign ecc_clear = !data_island_period || (counter == LAST_PIXEL);
  assign hdr_phase = counter < HDR_PIXELS;
  assign sub_phase = counter < SUB_PIXELS;

  // Pixel index: runs freely through back-to-back packets, restarts whenever the island drops
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      counter <= '0;
    end else if (!data_island_period) begin
      counter <= '0;
    end else begin
      counter <= counter + 5'd1;
    end
  end

  bch_ecc_step u_hdr_step (
    .ecc_in  (hdr_ecc),
    .data    (header[counter]),
    .ecc_out (hdr_ecc_next)
  );

  // Header ECC accumulates one bit per data pixel, then holds while its bits are sent
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      hdr_ecc <= '0;
    end else if (ecc_clear) begin
      hdr_ecc <= '0;
    end else if (hdr_phase) begin
      hdr_ecc <= hdr_ecc_next;
    end
  end

  // During ECC pixels (24..31) the low three counter bits index the ECC byte directly
  assign hdr_bit = hdr_phase ? header[counter] : hdr_ecc[counter[2:0]];

  for (genvar g = 0; g < 4; g++) begin : g_sub
    logic [7:0] sub_ecc;
    logic [7:0] sub_ecc_mid;
    logic [7:0] sub_ecc_next;

    // Even bit first, odd bit second: two chained steps per pixel
    bch_ecc_step u_even_step (
      .ecc_in  (sub_ecc),
      .data    (sub[g][{counter, 1'b0}]),
      .ecc_out (sub_ecc_mid)
    );

    bch_ecc_step u_odd_step (
      .ecc_in  (sub_ecc_mid),
      .data    (sub[g][{counter, 1'b1}]),
      .ecc_out (sub_ecc_next)
    );

    // Subpacket ECC accumulates two bits per data pixel, then holds while its bits are sent
    always_ff @(posedge clk_pixel or negedge rst_n) begin
      if (!rst_n) begin
        sub_ecc <= '0;
      end else if (ecc_clear) begin
        sub_ecc <= '0;
      end else if (sub_phase) begin
        sub_ecc <= sub_ecc_next;
      end
    end

    // During ECC pixels (28..31) the low two counter bits select an ECC bit pair
    assign even_bits[g] = sub_phase ? sub[g][{counter, 1'b0}] : sub_ecc[{counter[1:0], 1'b0}];
    assign odd_bits[g]  = sub_phase ? sub[g][{counter, 1'b1}] : sub_ecc[{counter[1:0], 1'b1}];
  end

  assign packet_data = active ? {odd_bits, even_bits, hdr_bit} : 9'h000;
  assign packet_end  = active && (counter == LAST_PIXEL);

endmodule

// File: tb/tb_packet_assembler.sv
module tb_packet_assembler;

  typedef logic [3:0][55:0] subs_t;

  logic             clk_pixel;
  logic             rst_n;
  logic             data_island_period;
  logic [23:0]      header;
  subs_t            sub;
  logic [4:0]       counter;
  logic [8:0]       packet_data;
  logic             packet_end;

  int checks_total;
  int checks_passed;

  logic [8:0] exp_pd  [32];
  logic [8:0] seen_pd [32];

  packet_assembler dut (
    .clk_pixel          (clk_pixel),
    .rst_n              (rst_n),
    .data_island_period (data_island_period),
    .header             (header),
    .sub                (sub),
    .counter            (counter),
    .packet_data        (packet_data),
    .packet_end         (packet_end)
  );

  initial clk_pixel = 1'b0;
  always #5 clk_pixel = ~clk_pixel;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      checks_passed++;
    end
  endtask

  // Reference BCH over the first n LSB-first bits of d
  function automatic logic [7:0] bch(input logic [55:0] d, input int n);
    logic [7:0] e;
    e = 8'h00;
    for (int i = 0; i < n; i++) begin
      e = (e >> 1) ^ ((e[0] ^ d[i]) ? 8'h83 : 8'h00);
    end
    return e;
  endfunction

  // Build the expected 32-pixel stream from full codewords {ecc, data}
  task automatic build_expected(input logic [23:0] h, input subs_t s);
    logic [31:0] hcw;
    logic [63:0] scw [4];
    hcw = {bch(56'(h), 24), h};
    for (int i = 0; i < 4; i++) scw[i] = {bch(s[i], 56), s[i]};
    for (int k = 0; k < 32; k++) begin
      for (int i = 0; i < 4; i++) begin
        exp_pd[k][i + 1] = scw[i][2 * k];
        exp_pd[k][i + 5] = scw[i][2 * k + 1];
      end
      exp_pd[k][0] = hcw[k];
    end
  endtask

  // Entered at a negedge; drives npix pixels of one packet and leaves at a negedge
  task automatic run_packet(input logic [23:0] h, input subs_t s, input int npix);
    build_expected(h, s);
    for (int k = 0; k < npix; k++) begin
      data_island_period = 1'b1;
      header = h;
      sub = s;
      #1;
      check_eq($sformatf("counter k=%0d", k), 32'(counter), 32'(k));
      check_eq($sformatf("packet_data k=%0d", k), 32'(packet_data), 32'(exp_pd[k]));
      check_eq($sformatf("packet_end k=%0d", k), 32'(packet_end), 32'(k == 31));
      seen_pd[k] = packet_data;
      @(negedge clk_pixel);
    end
  endtask

  task automatic run_idle(input int n);
    for (int k = 0; k < n; k++) begin
      data_island_period = 1'b0;
      header = 24'($urandom());
      sub = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      #1;
      check_eq("idle packet_data", 32'(packet_data), 32'h0);
      check_eq("idle packet_end", 32'(packet_end), 32'h0);
      @(negedge clk_pixel);
    end
  endtask

  function automatic subs_t rand_subs();
    subs_t s;
    for (int i = 0; i < 4; i++) s[i] = 56'({$urandom(), $urandom()});
    return s;
  endfunction

  initial begin
    logic [7:0] got_ecc;
    subs_t zs;
    subs_t s2;
    checks_total = 0;
    checks_passed = 0;
    zs = '0;

    // Reset held with the island asserted
    rst_n = 1'b0;
    data_island_period = 1'b1;
    header = 24'hFFFFFF;
    sub = '1;
    repeat (3) @(negedge clk_pixel);
    #1;
    check_eq("reset counter", 32'(counter), 32'h0);
    check_eq("reset packet_data", 32'(packet_data), 32'h0);
    check_eq("reset packet_end", 32'(packet_end), 32'h0);
    @(negedge clk_pixel);
    rst_n = 1'b1;

    // Release mid-island: fresh packet at pixel 0, all-zero content
    run_packet(24'h0, zs, 32);

    // Header = 1, known header ECC 8'h4A
    run_packet(24'h000001, zs, 32);
    check_eq("hdr1 pixel0 bit", 32'(seen_pd[0][0]), 32'h1);
    for (int k = 0; k < 8; k++) got_ecc[k] = seen_pd[24 + k][0];
    check_eq("hdr1 ecc", 32'(got_ecc), 32'h4A);

    // Subpacket 2 top data bit
    s2 = '0;
    s2[2] = 56'h80000000000000;
    run_packet(24'h0, s2, 32);
    check_eq("sub2 bit55 pixel27", 32'(seen_pd[27][7]), 32'h1);

    // 64 random back-to-back packets
    for (int p = 0; p < 64; p++) run_packet(24'($urandom()), rand_subs(), 32);

    // Abort at pixel 10, then a new packet
    run_packet(24'($urandom()), rand_subs(), 10);
    run_idle(3);
    run_packet(24'($urandom()), rand_subs(), 32);

    // Asynchronous reset mid-packet
    run_packet(24'($urandom()), rand_subs(), 7);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async reset counter", 32'(counter), 32'h0);
    check_eq("async reset packet_data", 32'(packet_data), 32'h0);
    @(negedge clk_pixel);
    rst_n = 1'b1;
    run_packet(24'($urandom()), rand_subs(), 32);
    run_idle(2);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/packet_assembler.md
PACKET_ASSEMBLER -- requirements
Module: packet_assembler

Interface
REQ-001 SHALL have parameters: none; all widths are fixed by HDMI 1.4 data-island packet format.
REQ-002 SHALL have port `clk_pixel`, input, 1 bit: pixel clock; the only clock of the block.
REQ-003 SHALL have port `rst_n`, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port `data_island_period`, input, 1 bit: high while a data-island packet is being transmitted.
REQ-005 SHALL have port `header`, input, 24 bits: packet header HB2:HB1:HB0, LSB sent first; held stable by upstream for the whole 32-pixel packet.
REQ-006 SHALL have port `sub[3:0]`, input, 4x56 bits: subpackets 0..3, each SB6..SB0, LSB first; held stable for the whole packet.
REQ-007 SHALL have port `counter`, output, 5 bits: pixel index 0..31 within the current packet.
REQ-008 SHALL have port `packet_data`, output, 9 bits: [0] = TMDS ch0 bit2 stream; [4:1] = even bits of sub0..3; [8:5] = odd bits of sub0..3.
REQ-009 SHALL have port `packet_end`, output, 1 bit: single-cycle pulse on the last pixel (counter==31) of each packet.

Function
REQ-010 `counter` SHALL increment by 1 on each `clk_pixel` edge while `data_island_period`=1, wrapping 31->0, so back-to-back packets are contiguous.
REQ-011 `counter` SHALL be forced to 0 on any cycle with `data_island_period`=0.
REQ-012 At counter k=0..23, `packet_data[0]` SHALL be header[k].
REQ-013 At counter k=24..31, `packet_data[0]` SHALL be header ECC bit (k-24).
REQ-014 At counter k=0..27, `packet_data[i+1]` SHALL be sub[i][2k] and `packet_data[i+5]` SHALL be sub[i][2k+1].
REQ-015 At counter k=28..31, the same two output bits SHALL carry subpacket-i ECC bits 2(k-28) and 2(k-28)+1.
REQ-016 The ECC SHALL be the HDMI BCH(32,24)/(64,56) code with G(x)=1+x^6+x^7+x^8.
REQ-017 The ECC SHALL be computed serially over LSB-first data bits: next = (ecc>>1) XOR ((ecc[0] XOR d) ? 8'h83 : 8'h00).
REQ-018 The header ECC register SHALL update once per pixel for k=0..23.
REQ-019 Each of the 4 subpacket ECC registers SHALL update twice per pixel (even bit, then odd bit) for k=0..27.
REQ-020 All five ECC registers SHALL hold their value during ECC transmission pixels.
REQ-021 All ECC registers SHALL be cleared to 0 when counter==31 or `data_island_period`=0, so each packet starts from zero.
REQ-022 `packet_data` SHALL be combinational from `counter`, the inputs and the ECC registers (zero latency), and SHALL be 9'h000 whenever `data_island_period`=0.
REQ-023 `packet_end` SHALL equal (`data_island_period` AND counter==31).
REQ-024 If `data_island_period` falls mid-packet, the partial packet SHALL be abandoned: counter=0 and ECC cleared on the next edge; no `packet_end` SHALL be produced for it.
REQ-025 No back-pressure SHALL exist; upstream is solely responsible for keeping `header`/`sub` stable for a full packet.

Reset
REQ-026 On `rst_n`=0, asynchronously: counter=0, all ECC registers=0, `packet_end`=0, `packet_data`=9'h000.
REQ-027 Deassertion of `rst_n` mid-island SHALL start a fresh packet at counter 0.

Structure
REQ-028 The shared package `hdmi_pkg` SHALL hold the BCH polynomial constant 8'h83, the packet length 32, the header data length 24 and the subpacket data length 56.
REQ-029 The block SHALL contain one sub-module `bch_ecc_step`: a combinational 1-bit ECC update, instanced once for the header and twice chained per subpacket.

Verification
REQ-030 Reset check: hold `rst_n`=0 with `data_island_period`=1 -> counter=0, `packet_data`=0, `packet_end`=0.
REQ-031 All-zero header/sub over 32 pixels -> `packet_data`=0 every pixel; `packet_end` high only at pixel 31.
REQ-032 header=24'h000001, sub all zero -> pixel 0 `packet_data[0]`=1; pixels 24..31 emit header ECC 8'h4A LSB-first.
REQ-033 Random header/sub over 64 back-to-back packets -> every bit matches a software BCH model; counter wraps 31->0 without a gap.
REQ-034 `data_island_period` dropped at pixel 10, then re-raised -> counter restarts at 0; ECC equals the model for the new packet only; no `packet_end` for the aborted packet.
REQ-035 sub[2]=56'h80000000000000 (bit 55 set) -> pixel 27 `packet_data[7]`=1; subpacket-2 ECC matches the model at pixels 28..31.
